// File: rtl/instr_pipe_tracker_if.sv
// Bundle of fetch-side controls and per-stage tracking outputs for instr_pipe_tracker.
interface instr_pipe_tracker_if #(
  parameter int IW    = 16,
  parameter int DEPTH = 5,
  parameter int CW    = 16
);
  logic                  instr_in;
  logic [IW-1:0]         instr_word;
  logic                  instr_in_valid;
  logic                  halt;
  logic                  stall;
  logic                  flush;
  logic                  fetch_ready;
  logic [DEPTH*IW-1:0]   stage_instr;
  logic [DEPTH-1:0]      stage_valid;
  logic [CW-1:0]         retire_cnt;
  logic [CW-1:0]         kill_cnt;

  modport master (
    output instr_word, instr_in_valid, halt, stall, flush,
    input  fetch_ready, stage_instr, stage_valid, retire_cnt, kill_cnt
  );

  modport slave (
    input  instr_word, instr_in_valid, halt, stall, flush,
    output fetch_ready, stage_instr, stage_valid, retire_cnt, kill_cnt
  );
endinterface

// File: rtl/instr_pipe_tracker.sv
// Instruction-tracking shift pipeline with halt, stall-bubble and flush-kill control,
// plus saturating retire and kill counters.
module instr_pipe_tracker #(
  parameter int            IW           = 16,
  parameter int            DEPTH        = 5,
  parameter logic [IW-1:0] NOP          = 16'hE800,
  parameter int            STALL_STAGE  = 1,
  parameter int            FLUSH_STAGES = 2,
  parameter int            CW           = 16
) (
  input logic              clk,
  input logic              rst,
  instr_pipe_tracker_if.slave bus
);

  logic [IW-1:0]    instr_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [IW-1:0]    instr_d [DEPTH];
  logic [DEPTH-1:0] vld_d;
  logic [IW-1:0]    instr_src [DEPTH];
  logic [DEPTH-1:0] vld_src;
  logic [CW-1:0]    retire_q, retire_d;
  logic [CW-1:0]    kill_q, kill_d;
  logic [7:0]       kill_inc;
  logic [DEPTH*IW-1:0] stage_flat;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [7:0] b);
    logic [CW+7:0] s;
    s = {8'd0, a} + {{CW{1'b0}}, b};
    if (s > {8'd0, {CW{1'b1}}}) return {CW{1'b1}};
    return s[CW-1:0];
  endfunction

  // Predecessor of every stage: stage 1 is fed from fetch, the rest from the stage before.
  always_comb begin
    instr_src[0] = bus.instr_in_valid ? bus.instr_word : NOP;
    vld_src[0]   = bus.instr_in_valid;
    for (int k = 1; k < DEPTH; k++) begin
      instr_src[k] = instr_p[k-1];
      vld_src[k]   = vld_p[k-1];
    end
  end

  always_comb begin
    instr_d  = instr_p;
    vld_d    = vld_p;
    retire_d = retire_q;
    kill_d   = kill_q;
    kill_inc = {7'd0, bus.instr_in_valid};
    for (int k = 0; k < DEPTH; k++) begin
      if (k < FLUSH_STAGES - 1 && vld_p[k]) kill_inc = kill_inc + 8'd1;
    end
    if (!bus.halt) begin
      if (vld_p[DEPTH-1]) retire_d = sat_add(retire_q, 8'd1);
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.flush) begin
          instr_d[k] = (k < FLUSH_STAGES) ? NOP  : instr_src[k];
          vld_d[k]   = (k < FLUSH_STAGES) ? 1'b0 : vld_src[k];
        end else if (bus.stall) begin
          if (k == STALL_STAGE) begin
            instr_d[k] = NOP;
            vld_d[k]   = 1'b0;
          end else if (k > STALL_STAGE) begin
            instr_d[k] = instr_src[k];
            vld_d[k]   = vld_src[k];
          end
        end else begin
          instr_d[k] = instr_src[k];
          vld_d[k]   = vld_src[k];
        end
      end
      if (bus.flush) kill_d = sat_add(kill_q, kill_inc);
    end
  end

  // Stage registers and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) instr_p[k] <= NOP;
      vld_p    <= '0;
      retire_q <= '0;
      kill_q   <= '0;
    end else begin
      instr_p  <= instr_d;
      vld_p    <= vld_d;
      retire_q <= retire_d;
      kill_q   <= kill_d;
    end
  end

  always_comb begin
    stage_flat = '0;
    for (int k = 0; k < DEPTH; k++) stage_flat[k*IW +: IW] = instr_p[k];
  end

  assign bus.stage_instr = stage_flat;
  assign bus.stage_valid = vld_p;
  assign bus.retire_cnt  = retire_q;
  assign bus.kill_cnt    = kill_q;
  assign bus.fetch_ready = !bus.halt && (bus.flush || !bus.stall);

endmodule

// File: tb/tb_instr_pipe_tracker.sv
// Self-checking bench for instr_pipe_tracker: directed scenarios plus randomized traffic
// against a list-based reference model of the stage contents.
module tb_instr_pipe_tracker;
  localparam int          IW    = 16;
  localparam int          DEPTH = 5;
  localparam logic [15:0] NOP   = 16'hE800;
  localparam int          SS    = 1;
  localparam int          FS    = 2;

  logic        clk;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_in_valid, halt, stall, flush;

  int checks   = 0;
  int failures = 0;

  logic [15:0]      m_instr [DEPTH];
  logic [DEPTH-1:0] m_vld;
  int m_ret, m_kill, m_ret2, m_kill2;

  instr_pipe_tracker_if #(.IW(IW), .DEPTH(DEPTH), .CW(16)) b0 ();
  instr_pipe_tracker_if #(.IW(IW), .DEPTH(DEPTH), .CW(2))  b1 ();

  assign b0.instr_in = 1'b0;
  assign b1.instr_in = 1'b0;
  assign b0.instr_word = instr_in;      assign b1.instr_word = instr_in;
  assign b0.instr_in_valid = instr_in_valid; assign b1.instr_in_valid = instr_in_valid;
  assign b0.halt = halt;   assign b1.halt = halt;
  assign b0.stall = stall; assign b1.stall = stall;
  assign b0.flush = flush; assign b1.flush = flush;

  instr_pipe_tracker #(.IW(IW), .DEPTH(DEPTH), .NOP(NOP), .STALL_STAGE(SS),
                       .FLUSH_STAGES(FS), .CW(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  instr_pipe_tracker #(.IW(IW), .DEPTH(DEPTH), .NOP(NOP), .STALL_STAGE(SS),
                       .FLUSH_STAGES(FS), .CW(2))  u1 (.clk(clk), .rst(rst), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat(input int a, input int b, input int mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < DEPTH; k++) m_instr[k] = NOP;
    m_vld = '0;
    m_ret = 0; m_kill = 0; m_ret2 = 0; m_kill2 = 0;
  endfunction

  // One clock of the reference: list of (word,valid) pairs moved per the control rules.
  function automatic void model_step();
    logic [15:0]      ni [DEPTH];
    logic [DEPTH-1:0] nv;
    int kinc;
    if (halt) return;
    if (m_vld[DEPTH-1]) begin
      m_ret  = sat(m_ret, 1, 65535);
      m_ret2 = sat(m_ret2, 1, 3);
    end
    for (int k = 0; k < DEPTH; k++) begin
      ni[k] = m_instr[k];
      nv[k] = m_vld[k];
    end
    if (flush) begin
      kinc = int'(instr_in_valid);
      for (int k = 0; k < FS - 1; k++) kinc += int'(m_vld[k]);
      m_kill  = sat(m_kill, kinc, 65535);
      m_kill2 = sat(m_kill2, kinc, 3);
      for (int k = DEPTH - 1; k >= FS; k--) begin ni[k] = m_instr[k-1]; nv[k] = m_vld[k-1]; end
      for (int k = 0; k < FS; k++) begin ni[k] = NOP; nv[k] = 1'b0; end
    end else if (stall) begin
      for (int k = DEPTH - 1; k > SS; k--) begin ni[k] = m_instr[k-1]; nv[k] = m_vld[k-1]; end
      ni[SS] = NOP; nv[SS] = 1'b0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin ni[k] = m_instr[k-1]; nv[k] = m_vld[k-1]; end
      ni[0] = instr_in_valid ? instr_in : NOP;
      nv[0] = instr_in_valid;
    end
    for (int k = 0; k < DEPTH; k++) m_instr[k] = ni[k];
    m_vld = nv;
  endfunction

  task automatic drive(input bit v, input logic [15:0] d, input bit h, input bit s, input bit f);
    instr_in = d; instr_in_valid = v; halt = h; stall = s; flush = f;
    model_step();
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 16'h0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    edge_wait();
    edge_wait();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [DEPTH*IW-1:0] all_nop;
    for (int k = 0; k < DEPTH; k++) all_nop[k*IW +: IW] = NOP;
    do_reset();
    checks++;
    if (b0.stage_instr !== all_nop || b0.stage_valid !== 5'b0 || b0.retire_cnt !== 16'd0 || b0.kill_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_idle instr=%h vld=%b ret=%0d kill=%0d required all NOP, 0", b0.stage_instr, b0.stage_valid, b0.retire_cnt, b0.kill_cnt);
    end
    drive(1, 16'h0101, 0, 0, 0); edge_wait();
    drive(1, 16'h0202, 0, 0, 0); edge_wait();
    drive(1, 16'h0303, 0, 0, 1); edge_wait();
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (b0.stage_instr !== all_nop || b0.stage_valid !== 5'b0 || b0.kill_cnt !== 16'd0 || b1.kill_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_async instr=%h vld=%b kill=%0d required all NOP, vld 0, kill 0", b0.stage_instr, b0.stage_valid, b0.kill_cnt);
    end
    instr_in = 16'h0404; instr_in_valid = 1'b1;
    edge_wait();
    checks++;
    if (b0.stage_valid !== 5'b0 || b0.stage_instr[IW-1:0] !== NOP) begin
      failures++;
      $display("FAIL reset_held vld=%b s1=%h required 00000 and %h", b0.stage_valid, b0.stage_instr[IW-1:0], NOP);
    end
    instr_in_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    logic [15:0] words [3];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      if (c <= 3) drive(1, words[c-1], 0, 0, 0);
      else        drive(0, 16'h0, 0, 0, 0);
      edge_wait();
      if (c == 5) begin
        checks++;
        if (b0.stage_instr[4*IW +: IW] !== 16'h1111 || b0.stage_valid[4] !== 1'b1) begin
          failures++;
          $display("FAIL stream_stage5 got=%h/%b required 1111/1", b0.stage_instr[4*IW +: IW], b0.stage_valid[4]);
        end
      end
      checks++;
      if (b0.retire_cnt !== 16'(m_ret)) begin
        failures++;
        $display("FAIL stream_retire edge=%0d got=%0d required %0d", c, b0.retire_cnt, m_ret);
      end
    end
    checks++;
    if (b0.retire_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stream_retire_total got=%0d required 3", b0.retire_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 16'h000B, 0, 0, 0); edge_wait();
    drive(1, 16'h000A, 0, 0, 0); edge_wait();
    for (int c = 0; c < 2; c++) begin
      drive(1, 16'h000C, 0, 1, 0);
      #1;
      checks++;
      if (b0.fetch_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_fetch_ready got=%b required 0", b0.fetch_ready);
      end
      edge_wait();
      checks++;
      if (b0.stage_instr[IW-1:0] !== 16'h000A || b0.stage_valid[0] !== 1'b1 ||
          b0.stage_valid[1] !== 1'b0 || b0.stage_instr[IW +: IW] !== NOP ||
          b0.stage_instr[(c+2)*IW +: IW] !== 16'h000B || b0.stage_valid[c+2] !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d instr=%h vld=%b required s1=000a s2 bubble s%0d=000b", c, b0.stage_instr, b0.stage_valid, c+3);
      end
    end
  endtask

  task automatic test_flush();
    int k0;
    do_reset();
    drive(1, 16'h0031, 0, 0, 0); edge_wait();
    drive(1, 16'h0032, 0, 0, 0); edge_wait();
    drive(1, 16'h0033, 0, 0, 0); edge_wait();
    k0 = m_kill;
    drive(1, 16'h0034, 0, 0, 1); edge_wait();
    checks++;
    if (b0.stage_valid !== 5'b01100 || b0.stage_instr[IW-1:0] !== NOP || b0.stage_instr[IW +: IW] !== NOP ||
        b0.stage_instr[2*IW +: IW] !== 16'h0032 || b0.stage_instr[3*IW +: IW] !== 16'h0031) begin
      failures++;
      $display("FAIL flush_stages instr=%h vld=%b required s1,s2 NOP s3=0032 s4=0031 vld=01100", b0.stage_instr, b0.stage_valid);
    end
    checks++;
    if (b0.kill_cnt !== 16'(k0 + 2)) begin
      failures++;
      $display("FAIL flush_kill got=%0d required %0d", b0.kill_cnt, k0 + 2);
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 16'h0041, 0, 0, 0); edge_wait();
    drive(1, 16'h0042, 0, 0, 0); edge_wait();
    drive(1, 16'h0043, 0, 0, 0); edge_wait();
    drive(1, 16'h0044, 1, 1, 1);
    #1;
    checks++;
    if (b0.fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL halt_fetch_ready got=%b required 0", b0.fetch_ready);
    end
    edge_wait();
    checks++;
    if (b0.stage_valid !== 5'b00111 || b0.stage_instr[IW-1:0] !== 16'h0043 ||
        b0.stage_instr[2*IW +: IW] !== 16'h0041 || b0.kill_cnt !== 16'd0 || b0.retire_cnt !== 16'd0) begin
      failures++;
      $display("FAIL halt_freeze instr=%h vld=%b kill=%0d ret=%0d required unchanged", b0.stage_instr, b0.stage_valid, b0.kill_cnt, b0.retire_cnt);
    end
    drive(1, 16'h0045, 0, 1, 1);
    #1;
    checks++;
    if (b0.fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_over_stall_ready got=%b required 1", b0.fetch_ready);
    end
    edge_wait();
    checks++;
    if (b0.stage_valid !== 5'b01100 || b0.stage_instr[2*IW +: IW] !== 16'h0042 ||
        b0.stage_instr[3*IW +: IW] !== 16'h0041 || b0.kill_cnt !== 16'd2) begin
      failures++;
      $display("FAIL flush_over_stall instr=%h vld=%b kill=%0d required s3=0042 s4=0041 kill=2", b0.stage_instr, b0.stage_valid, b0.kill_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c < 5) drive(1, 16'(16'h0500 + c), 0, 0, 0);
      else       drive(0, 16'h0, 0, 0, 0);
      edge_wait();
      checks++;
      if (b1.retire_cnt !== 2'(m_ret2)) begin
        failures++;
        $display("FAIL sat_retire cyc=%0d got=%0d required %0d", c, b1.retire_cnt, m_ret2);
      end
    end
    checks++;
    if (b1.retire_cnt !== 2'd3 || b0.retire_cnt !== 16'd5) begin
      failures++;
      $display("FAIL sat_final cw2=%0d cw16=%0d required 3 and 5", b1.retire_cnt, b0.retire_cnt);
    end
  endtask

  task automatic test_random();
    bit v, h, s, f;
    bit bad;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 9) < 7);
      h = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 9) == 0);
      drive(v, 16'($urandom), h, s, f);
      #1;
      checks++;
      if (b0.fetch_ready !== (!h && (f || !s))) begin
        failures++;
        $display("FAIL rand_fetch_ready cyc=%0d got=%b h=%b s=%b f=%b", c, b0.fetch_ready, h, s, f);
      end
      edge_wait();
      bad = 1'b0;
      for (int k = 0; k < DEPTH; k++) if (b0.stage_instr[k*IW +: IW] !== m_instr[k]) bad = 1'b1;
      checks++;
      if (bad || b0.stage_valid !== m_vld) begin
        failures++;
        $display("FAIL rand_stages cyc=%0d instr=%h vld=%b required vld=%b s1=%h s5=%h", c, b0.stage_instr, b0.stage_valid, m_vld, m_instr[0], m_instr[DEPTH-1]);
      end
      checks++;
      if (b0.retire_cnt !== 16'(m_ret) || b0.kill_cnt !== 16'(m_kill) ||
          b1.retire_cnt !== 2'(m_ret2) || b1.kill_cnt !== 2'(m_kill2)) begin
        failures++;
        $display("FAIL rand_counters cyc=%0d ret=%0d kill=%0d ret2=%0d kill2=%0d required %0d %0d %0d %0d",
                 c, b0.retire_cnt, b0.kill_cnt, b1.retire_cnt, b1.kill_cnt, m_ret, m_kill, m_ret2, m_kill2);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    instr_in = 16'h0; instr_in_valid = 1'b0; halt = 1'b0; stall = 1'b0; flush = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_priority();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
